// File: rtl/move_gather_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : move_gather_arbiter_pkg
// Purpose  : Shared definitions for the move-gather path: default move word
//            width, number of square generators per group, move flag bit
//            positions and the gather FSM state encoding.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package move_gather_arbiter_pkg;

  localparam int MOVE_W = 48;  // move word width
  localparam int NSQ    = 8;   // square generators per column

  // Move flag field bit positions ([invalid][promote][pawn][pawn2][ep][castle][capture])
  localparam int FLG_CAPTURE = 0;
  localparam int FLG_CASTLE  = 1;
  localparam int FLG_EP      = 2;
  localparam int FLG_PAWN2   = 3;
  localparam int FLG_PAWN    = 4;
  localparam int FLG_PROMOTE = 5;
  localparam int FLG_INVALID = 6;
  localparam int FLG_W       = 7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } gather_state_t;

endpackage
`default_nettype wire

// File: rtl/move_gather_arbiter_fifo.sv
`default_nettype none
// ============================================================================
// Module   : move_gather_arbiter_fifo
// Purpose  : Synchronous first-word-fall-through FIFO with occupancy count.
//            Push and pop in the same cycle are both honoured, including at
//            full; a pop while empty is ignored. out_data reads 0 when empty.
// Ports    : clk, reset_n (async active-low), flush (sync empty),
//            push/push_data, pop, out_valid/out_data (head), count.
// Revision : 1.0 - initial release
// ============================================================================
module move_gather_arbiter_fifo #(
  parameter int DW    = 48,
  parameter int DEPTH = 16
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         flush,
  input  logic                         push,
  input  logic [DW-1:0]                push_data,
  input  logic                         pop,
  output logic                         out_valid,
  output logic [DW-1:0]                out_data,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr_q;
  logic [AW-1:0] wr_ptr_q;
  logic [CW-1:0] count_q;
  logic          pop_ok;
  logic          push_ok;

  assign pop_ok  = pop & (count_q != '0);
  // A push at full is only legal when the head leaves in the same cycle.
  assign push_ok = push & ((count_q != CW'(DEPTH)) | pop_ok);

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_q] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign out_valid = (count_q != '0);
  assign out_data  = out_valid ? mem[rd_ptr_q] : '0;
  assign count     = count_q;

endmodule
`default_nettype wire

// File: rtl/move_gather_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : move_gather_arbiter
// Purpose  : Drains NCH per-square move FIFOs, one whole channel at a time,
//            into a local FWFT FIFO. Channels are granted once per pass when
//            their ch_done is high, in round-robin (RR=1) or highest-index
//            fixed priority (RR=0) order.
// Ports    : clk, reset_n, start, clear, ch_done/ch_empty/ch_rden/ch_data
//            (channel side), out_valid/out_ready/out_data/out_count (stream
//            side), busy (WAIT or DRAIN), done (pass complete, registered).
// Revision : 1.0 - initial release
// ============================================================================
module move_gather_arbiter
  import move_gather_arbiter_pkg::*;
#(
  parameter int NCH   = NSQ,
  parameter int DW    = MOVE_W,
  parameter int DEPTH = 16,
  parameter int RR    = 1
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         start,
  input  logic                         clear,
  input  logic [NCH-1:0]               ch_done,
  input  logic [NCH-1:0]               ch_empty,
  output logic [NCH-1:0]               ch_rden,
  input  logic [NCH*DW-1:0]            ch_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DW-1:0]                out_data,
  output logic [$clog2(DEPTH+1)-1:0]   out_count,
  output logic                         busy,
  output logic                         done
);

  localparam int PW = $clog2(NCH);

  gather_state_t  state_q, state_d;
  logic [NCH-1:0] drained_q;
  logic [PW-1:0]  rr_ptr_q;
  logic [PW-1:0]  sel_q;
  logic           wr_pend_q;
  logic           done_q;

  logic [NCH-1:0] cand;
  logic           grant_found;
  logic [PW-1:0]  grant_idx;
  logic           sel_empty;
  logic           room;
  logic           rden_sel;
  logic           start_ok;
  logic           fifo_empty;

  assign cand      = ch_done & ~drained_q;
  assign sel_empty = ch_empty[sel_q];
  // Keep one slot free for a word that is already in flight from the channel.
  assign room      = (int'(out_count) + int'(wr_pend_q)) <= (DEPTH - 2);
  assign rden_sel  = (state_q == ST_DRAIN) & ~sel_empty & room;
  assign start_ok  = start & ~clear & ((state_q == ST_IDLE) | (state_q == ST_DONE));
  assign fifo_empty = (out_count == '0);

  generate
    if (RR != 0) begin : g_rr
      logic [PW-1:0] rr_idx;
      // Rotating priority: search starts just after the last granted channel.
      always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        rr_idx      = '0;
        for (int i = 1; i <= NCH; i++) begin
          rr_idx = PW'((int'(rr_ptr_q) + i) % NCH);
          if (!grant_found && cand[rr_idx]) begin
            grant_found = 1'b1;
            grant_idx   = rr_idx;
          end
        end
      end
    end else begin : g_fp
      // Ascending scan, last hit wins, so the highest index takes priority.
      always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int i = 0; i < NCH; i++) begin
          if (cand[PW'(i)]) begin
            grant_found = 1'b1;
            grant_idx   = PW'(i);
          end
        end
      end
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (start) state_d = ST_WAIT;
      ST_WAIT: begin
        if (grant_found) begin
          state_d = ST_DRAIN;
        end else if ((&drained_q) && !wr_pend_q && fifo_empty) begin
          state_d = ST_DONE;
        end
      end
      ST_DRAIN: if (sel_empty) state_d = ST_WAIT;
      ST_DONE:  if (start) state_d = ST_WAIT;
      default:  state_d = ST_IDLE;
    endcase
    if (clear) state_d = ST_IDLE;
  end

  always_comb begin
    ch_rden        = '0;
    ch_rden[sel_q] = rden_sel;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      drained_q <= '0;
      rr_ptr_q  <= '0;
      sel_q     <= '0;
      wr_pend_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      done_q    <= (state_d == ST_DONE);
      wr_pend_q <= clear ? 1'b0 : rden_sel;
      if (clear || start_ok) begin
        drained_q <= '0;
      end else if ((state_q == ST_DRAIN) && sel_empty) begin
        drained_q[sel_q] <= 1'b1;
      end
      // sel_q only moves in WAIT, where no write is pending, so the final
      // in-flight word of the previous channel is always muxed correctly.
      if (!clear && (state_q == ST_WAIT) && grant_found) begin
        sel_q    <= grant_idx;
        rr_ptr_q <= grant_idx;
      end
    end
  end

  move_gather_arbiter_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (clear),
    .push      (wr_pend_q),
    .push_data (ch_data[int'(sel_q)*DW +: DW]),
    .pop       (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .count     (out_count)
  );

  assign busy = (state_q == ST_WAIT) || (state_q == ST_DRAIN);
  assign done = done_q;

endmodule
`default_nettype wire

// File: tb/tb_move_gather_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_move_gather_arbiter
// Purpose  : Directed self-checking bench. dut_a is round-robin, dut_b is
//            fixed priority; both use 8 channels, 16-bit words, depth 4.
//            A queue per channel models the square FIFOs (1-cycle latency).
// Revision : 1.0 - initial release
// ============================================================================
module tb_move_gather_arbiter;

  logic        clk;
  logic        reset_n;
  logic        start     [2];
  logic        clear     [2];
  logic        out_ready [2];
  logic [7:0]  ch_done   [2];
  logic [7:0]  ch_empty  [2];
  logic [7:0]  ch_rden   [2];
  logic [127:0] ch_data  [2];
  logic        out_valid [2];
  logic [15:0] out_data  [2];
  logic [2:0]  out_count [2];
  logic        busy      [2];
  logic        done      [2];

  logic [15:0] q    [16][$];
  logic [15:0] dbuf [16];
  logic [15:0] expq [2][$];

  int nchk = 0;
  int nerr = 0;

  move_gather_arbiter #(.NCH(8), .DW(16), .DEPTH(4), .RR(1)) dut_a (
    .clk(clk), .reset_n(reset_n), .start(start[0]), .clear(clear[0]),
    .ch_done(ch_done[0]), .ch_empty(ch_empty[0]), .ch_rden(ch_rden[0]),
    .ch_data(ch_data[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .out_data(out_data[0]), .out_count(out_count[0]), .busy(busy[0]), .done(done[0])
  );

  move_gather_arbiter #(.NCH(8), .DW(16), .DEPTH(4), .RR(0)) dut_b (
    .clk(clk), .reset_n(reset_n), .start(start[1]), .clear(clear[1]),
    .ch_done(ch_done[1]), .ch_empty(ch_empty[1]), .ch_rden(ch_rden[1]),
    .ch_data(ch_data[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .out_data(out_data[1]), .out_count(out_count[1]), .busy(busy[1]), .done(done[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    for (int u = 0; u < 2; u++) begin
      ch_data[u] = '0;
      for (int k = 0; k < 8; k++) ch_data[u][k*16 +: 16] = dbuf[u*8+k];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    assert (got === exp) else begin
      nerr++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic refresh_empty();
    for (int u = 0; u < 2; u++)
      for (int k = 0; k < 8; k++) ch_empty[u][k] = (q[u*8+k].size() == 0);
  endtask

  task automatic load(input int u, input int k, input int n, input logic [15:0] base);
    for (int i = 0; i < n; i++) q[u*8+k].push_back(base + 16'(i));
    refresh_empty();
  endtask

  // One clock: sample handshakes at the negedge, then model the channel
  // FIFOs and the consumer just after the rising edge.
  task automatic tick();
    logic [7:0]  rd [2];
    logic        pp [2];
    logic [15:0] pd [2];
    logic [15:0] e;
    @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      rd[u] = ch_rden[u];
      pp[u] = out_valid[u] & out_ready[u];
      pd[u] = out_data[u];
    end
    @(posedge clk);
    #1;
    for (int u = 0; u < 2; u++) begin
      check("rden_onehot", 32'($onehot0(rd[u])), 1);
      for (int k = 0; k < 8; k++) begin
        if (rd[u][k]) begin
          check("rden_nonempty", 32'(q[u*8+k].size() != 0), 1);
          if (q[u*8+k].size() != 0) dbuf[u*8+k] = q[u*8+k].pop_front();
        end
      end
      if (pp[u]) begin
        check("pop_avail", 32'(expq[u].size() != 0), 1);
        if (expq[u].size() != 0) begin
          e = expq[u].pop_front();
          check("pop_data", 32'(pd[u]), 32'(e));
        end
      end
    end
    refresh_empty();
  endtask

  initial begin
    reset_n = 1'b0;
    for (int u = 0; u < 2; u++) begin
      start[u] = 1'b0; clear[u] = 1'b0; out_ready[u] = 1'b0; ch_done[u] = '0;
    end
    for (int i = 0; i < 16; i++) dbuf[i] = '0;
    refresh_empty();
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 32'(out_valid[0]), 0);
    check("rst_count", 32'(out_count[0]), 0);
    check("rst_rden",  32'(ch_rden[0]), 0);
    check("rst_busy",  32'(busy[0]), 0);
    check("rst_done",  32'(done[0]), 0);
    check("rst_data",  32'(out_data[0]), 0);
    reset_n = 1'b1;
    tick();

    // 1: round robin, two words per channel, order 1..7 then 0
    for (int k = 0; k < 8; k++) load(0, k, 2, 16'h1000 + 16'(k*16));
    for (int j = 1; j <= 8; j++)
      for (int i = 0; i < 2; i++) expq[0].push_back(16'h1000 + 16'((j % 8)*16 + i));
    ch_done[0] = 8'hFF; out_ready[0] = 1'b1; start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    check("t1_busy", 32'(busy[0]), 1);
    for (int n = 0; n < 300 && !done[0]; n++) tick();
    check("t1_done", 32'(done[0]), 1);
    check("t1_all_popped", 32'(expq[0].size()), 0);
    check("t1_idle_busy", 32'(busy[0]), 0);

    // 4: granted channel that is already empty
    ch_done[0] = 8'h08; start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    check("t4_done_drop", 32'(done[0]), 0);
    tick();
    check("t4_busy", 32'(busy[0]), 1);
    check("t4_no_rden", 32'(ch_rden[0]), 0);
    check("t4_not_yet", 32'(dut_a.drained_q[3]), 0);
    tick();
    check("t4_drained", 32'(dut_a.drained_q[3]), 1);
    clear[0] = 1'b1;
    tick();
    clear[0] = 1'b0;
    check("t4_clear_busy", 32'(busy[0]), 0);

    // 3: backpressure, depth 4, ten words on channel 6
    load(0, 6, 10, 16'h3000);
    for (int i = 0; i < 10; i++) expq[0].push_back(16'h3000 + 16'(i));
    ch_done[0] = 8'h40; out_ready[0] = 1'b0; start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    for (int n = 0; n < 12; n++) begin
      tick();
      check("t3_no_overflow", 32'(out_count[0] <= 3), 1);
    end
    check("t3_stall_count", 32'(out_count[0]), 3);
    check("t3_stall_rden", 32'(ch_rden[0]), 0);
    check("t3_words_read", 32'(q[6].size()), 7);
    // 5: release; after one pop the FIFO settles into push+pop per cycle
    out_ready[0] = 1'b1;
    tick();
    check("t5_count_a", 32'(out_count[0]), 2);
    tick();
    check("t5_count_b", 32'(out_count[0]), 1);
    tick();
    check("t5_count_c", 32'(out_count[0]), 1);
    tick();
    check("t5_count_d", 32'(out_count[0]), 1);
    for (int n = 0; n < 100 && expq[0].size() != 0; n++) tick();
    check("t3_all_popped", 32'(expq[0].size()), 0);
    check("t3_empty", 32'(out_count[0]), 0);

    // 2: fixed priority, channel 5 before channel 2
    load(1, 2, 3, 16'h2200);
    load(1, 5, 3, 16'h2500);
    for (int i = 0; i < 3; i++) expq[1].push_back(16'h2500 + 16'(i));
    for (int i = 0; i < 3; i++) expq[1].push_back(16'h2200 + 16'(i));
    ch_done[1] = 8'h24; out_ready[1] = 1'b1; start[1] = 1'b1;
    tick();
    start[1] = 1'b0;
    for (int n = 0; n < 60 && expq[1].size() != 0; n++) tick();
    check("t2_all_popped", 32'(expq[1].size()), 0);
    repeat (4) tick();
    check("t2_empty", 32'(out_count[1]), 0);

    // 6a: clear mid-drain, then restart re-drains every done channel
    clear[0] = 1'b1;
    tick();
    clear[0] = 1'b0;
    load(0, 1, 6, 16'h6100);
    load(0, 4, 2, 16'h6400);
    ch_done[0] = 8'h12; out_ready[0] = 1'b0; start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    repeat (6) tick();
    check("t6_pre_count", 32'(out_count[0]), 3);
    check("t6_pre_busy", 32'(busy[0]), 1);
    clear[0] = 1'b1;
    tick();
    clear[0] = 1'b0;
    check("t6_clr_count", 32'(out_count[0]), 0);
    check("t6_clr_valid", 32'(out_valid[0]), 0);
    check("t6_clr_busy", 32'(busy[0]), 0);
    check("t6_ch1_left", 32'(q[1].size()), 3);
    for (int i = 0; i < q[4].size(); i++) expq[0].push_back(q[4][i]);
    for (int i = 0; i < q[1].size(); i++) expq[0].push_back(q[1][i]);
    out_ready[0] = 1'b1; start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    for (int n = 0; n < 100 && expq[0].size() != 0; n++) tick();
    check("t6_redrain", 32'(expq[0].size()), 0);

    // 6b: asynchronous reset mid-drain
    clear[0] = 1'b1;
    tick();
    clear[0] = 1'b0;
    load(0, 3, 5, 16'h7300);
    ch_done[0] = 8'h08; out_ready[0] = 1'b0; start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    repeat (6) tick();
    check("t6_rst_pre_busy", 32'(busy[0]), 1);
    check("t6_rst_pre_count", 32'(out_count[0]), 3);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("t6_rst_valid", 32'(out_valid[0]), 0);
    check("t6_rst_count", 32'(out_count[0]), 0);
    check("t6_rst_busy",  32'(busy[0]), 0);
    check("t6_rst_rden",  32'(ch_rden[0]), 0);
    check("t6_rst_done",  32'(done[0]), 0);
    check("t6_rst_data",  32'(out_data[0]), 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
`default_nettype wire
